// File: rtl/sram_array_wctl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_array_wctl_if
//  Description : Bundles the refill, store, read-hazard and SRAM write-port
//                signals of sram_array_wctl.
//                slave  - controller side (sram_array_wctl)
//                master - client side (pipeline, refill engine, testbench)
//  Signals     : io_refill_* beat handshake, io_st_* store handshake,
//                io_rd_* read probe/hazard, sram_* array ports,
//                io_busy / io_init_done status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sram_array_wctl_if #(
    parameter int SETS   = 128,
    parameter int BANKS  = 8,
    parameter int DATA_W = 32
);
    localparam int ADDR_W = $clog2(SETS);
    localparam int BANK_W = $clog2(BANKS);
    localparam int LINE_W = BANKS * DATA_W;

    logic              io_refill_valid;
    logic              io_refill_ready;
    logic [ADDR_W-1:0] io_refill_addr;
    logic [DATA_W-1:0] io_refill_data;
    logic              io_refill_last;

    logic              io_st_valid;
    logic              io_st_ready;
    logic [ADDR_W-1:0] io_st_addr;
    logic [BANK_W-1:0] io_st_bank;
    logic [DATA_W-1:0] io_st_data;

    logic              io_rd_valid;
    logic [ADDR_W-1:0] io_rd_addr;
    logic              io_rd_hazard;

    logic [ADDR_W-1:0] sram_r_addr;
    logic              sram_w_en;
    logic [ADDR_W-1:0] sram_w_addr;
    logic [LINE_W-1:0] sram_w_data;
    logic [BANKS-1:0]  sram_w_maskOH;

    logic              io_busy;
    logic              io_init_done;

    modport slave (
        input  io_refill_valid, io_refill_addr, io_refill_data, io_refill_last,
        output io_refill_ready,
        input  io_st_valid, io_st_addr, io_st_bank, io_st_data,
        output io_st_ready,
        input  io_rd_valid, io_rd_addr,
        output io_rd_hazard,
        output sram_r_addr, sram_w_en, sram_w_addr, sram_w_data, sram_w_maskOH,
        output io_busy, io_init_done
    );

    modport master (
        output io_refill_valid, io_refill_addr, io_refill_data, io_refill_last,
        input  io_refill_ready,
        output io_st_valid, io_st_addr, io_st_bank, io_st_data,
        input  io_st_ready,
        output io_rd_valid, io_rd_addr,
        input  io_rd_hazard,
        input  sram_r_addr, sram_w_en, sram_w_addr, sram_w_data, sram_w_maskOH,
        input  io_busy, io_init_done
    );
endinterface
`default_nettype wire

// File: rtl/sram_array_wctl.sv
`default_nettype none
// ============================================================================
//  Module      : sram_array_wctl
//  Description : Write-port controller and RAW hazard tracker for the banked
//                cache data array. One write port is shared between a line
//                refill sequencer (beats gathered into a full-line write) and
//                a small store queue (single-word writes).
//                Priority on the write port: INIT sweep > COMMIT > store head.
//  Ports       : clk_i   - clock, all state on rising edge
//                rst_ni  - asynchronous active-low reset
//                bus     - sram_array_wctl_if.slave (handshakes, SRAM ports)
//  Options     : SRAM_WCTL_INIT_EN - when defined, zero-sweeps every set after
//                reset and blocks refills/stores/reads until finished.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_array_wctl #(
    parameter int SETS     = 128,
    parameter int BANKS    = 8,
    parameter int DATA_W   = 32,
    parameter int SQ_DEPTH = 2
) (
    input  wire logic        clk_i,
    input  wire logic        rst_ni,
    sram_array_wctl_if.slave bus
);
    localparam int ADDR_W = $clog2(SETS);
    localparam int BANK_W = $clog2(BANKS);
    localparam int LINE_W = BANKS * DATA_W;
    localparam int PTR_W  = (SQ_DEPTH > 1) ? $clog2(SQ_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_IDLE   = 2'd1,
        S_FILL   = 2'd2,
        S_COMMIT = 2'd3
    } state_e;

`ifdef SRAM_WCTL_INIT_EN
    localparam state_e RST_STATE = S_INIT;
`else
    localparam state_e RST_STATE = S_IDLE;
`endif

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   fill_addr_q, fill_addr_d;
    logic [BANK_W-1:0]   beat_q, beat_d;
    logic [BANKS-1:0]    rcvd_q, rcvd_d;
    logic [LINE_W-1:0]   line_q, line_d;

    logic [ADDR_W-1:0]   sq_addr_q [SQ_DEPTH];
    logic [BANK_W-1:0]   sq_bank_q [SQ_DEPTH];
    logic [DATA_W-1:0]   sq_data_q [SQ_DEPTH];
    logic [SQ_DEPTH-1:0] sq_vld_q;
    logic [PTR_W-1:0]    sq_wr_q, sq_rd_q;

    logic init_active;
    logic refill_fire;
    logic sq_full, sq_enq, sq_deq, sq_head_vld, sq_match;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SQ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

`ifdef SRAM_WCTL_INIT_EN
    logic [ADDR_W-1:0] init_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            init_cnt_q <= '0;
        else if (state_q == S_INIT)
            init_cnt_q <= init_cnt_q + ADDR_W'(1);
    end

    // Qualified by reset so the port is quiet while reset is held.
    assign init_active      = (state_q == S_INIT) && rst_ni;
    assign bus.io_init_done = (state_q != S_INIT);
`else
    assign init_active      = 1'b0;
    assign bus.io_init_done = 1'b1;
`endif

    assign bus.io_refill_ready = (state_q == S_IDLE) || (state_q == S_FILL);
    assign refill_fire         = bus.io_refill_valid && bus.io_refill_ready;

    // Full is judged on registered occupancy only; a dequeue in the same
    // cycle does not reopen the queue until the next cycle.
    assign sq_full         = &sq_vld_q;
    assign bus.io_st_ready = !sq_full && (state_q != S_INIT);
    assign sq_enq          = bus.io_st_valid && bus.io_st_ready;
    assign sq_head_vld     = sq_vld_q[sq_rd_q];
    assign sq_deq          = sq_head_vld && (state_q != S_INIT) && (state_q != S_COMMIT);

    // ---------------- refill FSM ----------------
    always_comb begin
        state_d     = state_q;
        fill_addr_d = fill_addr_q;
        beat_d      = beat_q;
        rcvd_d      = rcvd_q;
        line_d      = line_q;
        case (state_q)
`ifdef SRAM_WCTL_INIT_EN
            S_INIT: begin
                if (init_cnt_q == ADDR_W'(SETS - 1))
                    state_d = S_IDLE;
            end
`endif
            S_IDLE: begin
                if (refill_fire) begin
                    fill_addr_d           = bus.io_refill_addr;
                    line_d                = '0;
                    line_d[DATA_W-1:0]    = bus.io_refill_data;
                    rcvd_d                = BANKS'(1);
                    beat_d                = BANK_W'(1);
                    state_d               = bus.io_refill_last ? S_COMMIT : S_FILL;
                end
            end
            S_FILL: begin
                if (refill_fire) begin
                    line_d[beat_q*DATA_W +: DATA_W] = bus.io_refill_data;
                    rcvd_d[beat_q]                  = 1'b1;
                    beat_d                          = beat_q + BANK_W'(1);
                    // A full line commits even if the source never flags last.
                    if (bus.io_refill_last || (beat_q == BANK_W'(BANKS - 1)))
                        state_d = S_COMMIT;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RST_STATE;
            fill_addr_q <= '0;
            beat_q      <= '0;
            rcvd_q      <= '0;
            line_q      <= '0;
        end else begin
            state_q     <= state_d;
            fill_addr_q <= fill_addr_d;
            beat_q      <= beat_d;
            rcvd_q      <= rcvd_d;
            line_q      <= line_d;
        end
    end

    // ---------------- store queue ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sq_vld_q <= '0;
            sq_wr_q  <= '0;
            sq_rd_q  <= '0;
            for (int i = 0; i < SQ_DEPTH; i++) begin
                sq_addr_q[i] <= '0;
                sq_bank_q[i] <= '0;
                sq_data_q[i] <= '0;
            end
        end else begin
            if (sq_enq) begin
                sq_addr_q[sq_wr_q] <= bus.io_st_addr;
                sq_bank_q[sq_wr_q] <= bus.io_st_bank;
                sq_data_q[sq_wr_q] <= bus.io_st_data;
                sq_vld_q[sq_wr_q]  <= 1'b1;
                sq_wr_q            <= ptr_inc(sq_wr_q);
            end
            // Enqueue and dequeue never hit the same slot: a dequeue needs a
            // valid head, an enqueue needs a free slot, and wr==rd only when
            // the queue is completely empty or completely full.
            if (sq_deq) begin
                sq_vld_q[sq_rd_q] <= 1'b0;
                sq_rd_q           <= ptr_inc(sq_rd_q);
            end
        end
    end

    // ---------------- write port mux ----------------
    always_comb begin
        bus.sram_w_en     = 1'b0;
        bus.sram_w_addr   = '0;
        bus.sram_w_data   = '0;
        bus.sram_w_maskOH = '0;
        if (init_active) begin
            bus.sram_w_en     = 1'b1;
`ifdef SRAM_WCTL_INIT_EN
            bus.sram_w_addr   = init_cnt_q;
`endif
            bus.sram_w_maskOH = '1;
        end else if (state_q == S_COMMIT) begin
            bus.sram_w_en     = 1'b1;
            bus.sram_w_addr   = fill_addr_q;
            bus.sram_w_data   = line_q;
            bus.sram_w_maskOH = rcvd_q;
        end else if (sq_head_vld) begin
            bus.sram_w_en     = 1'b1;
            bus.sram_w_addr   = sq_addr_q[sq_rd_q];
            bus.sram_w_maskOH = BANKS'(1) << sq_bank_q[sq_rd_q];
            bus.sram_w_data[sq_bank_q[sq_rd_q]*DATA_W +: DATA_W] = sq_data_q[sq_rd_q];
        end
    end

    // ---------------- read hazard ----------------
    always_comb begin
        sq_match = 1'b0;
        for (int i = 0; i < SQ_DEPTH; i++)
            if (sq_vld_q[i] && (sq_addr_q[i] == bus.io_rd_addr))
                sq_match = 1'b1;
    end

    assign bus.io_rd_hazard = bus.io_rd_valid &&
                              (init_active || sq_match ||
                               (((state_q == S_FILL) || (state_q == S_COMMIT)) &&
                                (bus.io_rd_addr == fill_addr_q)));

    assign bus.sram_r_addr = bus.io_rd_addr;
    assign bus.io_busy     = (state_q == S_FILL) || (state_q == S_COMMIT) || (|sq_vld_q);

endmodule
`default_nettype wire

// File: tb/tb_sram_array_wctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_array_wctl
//  Description : Self-checking bench for sram_array_wctl. Every array write
//                is matched against an ordered scoreboard of expected writes;
//                cycle-exact corners are checked inline.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_array_wctl;
    localparam int SETS   = 128;
    localparam int BANKS  = 8;
    localparam int DATA_W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sram_array_wctl_if #(.SETS(SETS), .BANKS(BANKS), .DATA_W(DATA_W)) bus ();

    sram_array_wctl #(.SETS(SETS), .BANKS(BANKS), .DATA_W(DATA_W), .SQ_DEPTH(2)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]   addr;
        logic [7:0]   mask;
        logic [255:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_wide(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic logic [255:0] lane_mask(input logic [7:0] m);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < 8; k++)
            r[32*k +: 32] = {32{m[k]}};
        return r;
    endfunction

    function automatic logic [255:0] lane(input logic [2:0] bank, input logic [31:0] d);
        logic [255:0] r;
        r = '0;
        r[32*bank +: 32] = d;
        return r;
    endfunction

    task automatic push_wr(input logic [6:0] a, input logic [7:0] m, input logic [255:0] d);
        wr_t e;
        e.addr = a;
        e.mask = m;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every array write must match the oldest expected write.
    wr_t mon_e;
    always @(negedge clk) begin
        if (rst_n && bus.sram_w_en) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0h mask %0h expected no write",
                         bus.sram_w_addr, bus.sram_w_maskOH);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", 32'(bus.sram_w_addr), 32'(mon_e.addr));
                check("write_mask", 32'(bus.sram_w_maskOH), 32'(mon_e.mask));
                check_wide("write_data", bus.sram_w_data & lane_mask(mon_e.mask),
                           mon_e.data & lane_mask(mon_e.mask));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.io_refill_valid = 1'b0;
        bus.io_refill_addr  = '0;
        bus.io_refill_data  = '0;
        bus.io_refill_last  = 1'b0;
        bus.io_st_valid     = 1'b0;
        bus.io_st_addr      = '0;
        bus.io_st_bank      = '0;
        bus.io_st_data      = '0;
        bus.io_rd_valid     = 1'b0;
        bus.io_rd_addr      = '0;
    endtask

    task automatic do_reset(input bit check_init);
        rst_n = 1'b0;
        idle_inputs();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
`ifdef SRAM_WCTL_INIT_EN
        for (int i = 0; i < SETS; i++)
            push_wr(7'(i), 8'hFF, '0);
        rst_n = 1'b1;
        for (int i = 0; i < SETS; i++) begin
            @(negedge clk);
            if (check_init) begin
                check("init_done_low", 32'(bus.io_init_done), 32'd0);
                check("init_refill_ready", 32'(bus.io_refill_ready), 32'd0);
                check("init_st_ready", 32'(bus.io_st_ready), 32'd0);
            end
        end
        @(negedge clk);
        check("init_done_rise", 32'(bus.io_init_done), 32'd1);
        check("init_sweep_drained", 32'(exp_q.size()), 32'd0);
`else
        rst_n = 1'b1;
        @(negedge clk);
        check("init_done_tied", 32'(bus.io_init_done), 32'd1);
`endif
        tick();
    endtask

    task automatic send_beat(input logic [6:0] a, input logic [31:0] d, input logic last);
        int w;
        bus.io_refill_valid = 1'b1;
        bus.io_refill_addr  = a;
        bus.io_refill_data  = d;
        bus.io_refill_last  = last;
        w = 0;
        @(negedge clk);
        while (!bus.io_refill_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) fail_now("refill_ready_wait");
        tick();
        bus.io_refill_valid = 1'b0;
        bus.io_refill_last  = 1'b0;
    endtask

    task automatic send_store(input logic [6:0] a, input logic [2:0] b, input logic [31:0] d);
        int w;
        bus.io_st_valid = 1'b1;
        bus.io_st_addr  = a;
        bus.io_st_bank  = b;
        bus.io_st_data  = d;
        w = 0;
        @(negedge clk);
        while (!bus.io_st_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) fail_now("st_ready_wait");
        tick();
        bus.io_st_valid = 1'b0;
    endtask

    typedef struct {
        logic [6:0]  addr;
        logic [2:0]  bank;
        logic [31:0] data;
        logic [6:0]  rd_addr;
        logic [7:0]  exp_mask;
        logic        exp_haz;
    } st_vec_t;

    st_vec_t      vecs[4];
    logic [255:0] line;

    initial begin
        vecs[0] = '{7'h03, 3'd0, 32'h1111_0000, 7'h03, 8'h01, 1'b1};
        vecs[1] = '{7'h7F, 3'd7, 32'hCAFE_F00D, 7'h7E, 8'h80, 1'b0};
        vecs[2] = '{7'h40, 3'd3, 32'h0BAD_BEEF, 7'h40, 8'h08, 1'b1};
        vecs[3] = '{7'h00, 3'd6, 32'h1234_5678, 7'h01, 8'h40, 1'b0};

        // ---- reset values while reset is held ----
        idle_inputs();
        bus.io_rd_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_w_en", 32'(bus.sram_w_en), 32'd0);
        check("rst_mask", 32'(bus.sram_w_maskOH), 32'd0);
        check("rst_w_addr", 32'(bus.sram_w_addr), 32'd0);
        check_wide("rst_w_data", bus.sram_w_data, '0);
        check("rst_busy", 32'(bus.io_busy), 32'd0);
        check("rst_hazard", 32'(bus.io_rd_hazard), 32'd0);
`ifdef SRAM_WCTL_INIT_EN
        check("rst_init_done", 32'(bus.io_init_done), 32'd0);
`else
        check("rst_init_done", 32'(bus.io_init_done), 32'd1);
`endif
        do_reset(1'b1);

        // ---- table-driven isolated stores ----
        foreach (vecs[i]) begin
            push_wr(vecs[i].addr, vecs[i].exp_mask, lane(vecs[i].bank, vecs[i].data));
            send_store(vecs[i].addr, vecs[i].bank, vecs[i].data);
            bus.io_rd_valid = 1'b1;
            bus.io_rd_addr  = vecs[i].rd_addr;
            @(negedge clk);
            check("st_hazard_t1", 32'(bus.io_rd_hazard), 32'(vecs[i].exp_haz));
            check("st_w_en_t1", 32'(bus.sram_w_en), 32'd1);
            check("r_addr_pass", 32'(bus.sram_r_addr), 32'(vecs[i].rd_addr));
            tick();
            @(negedge clk);
            check("st_hazard_t2", 32'(bus.io_rd_hazard), 32'd0);
            check("st_busy_t2", 32'(bus.io_busy), 32'd0);
            tick();
            bus.io_rd_valid = 1'b0;
        end

        // ---- full 8-beat refill, address taken from first beat only ----
        line = '0;
        for (int k = 0; k < 8; k++) line[32*k +: 32] = 32'h100 + 32'(k);
        push_wr(7'h15, 8'hFF, line);
        for (int k = 0; k < 8; k++)
            send_beat((k == 0) ? 7'h15 : 7'h7F, 32'h100 + 32'(k), k == 7);
        @(negedge clk);
        check("commit_refill_ready", 32'(bus.io_refill_ready), 32'd0);
        check("commit_w_en", 32'(bus.sram_w_en), 32'd1);
        check("commit_busy", 32'(bus.io_busy), 32'd1);
        tick();
        @(negedge clk);
        check("post_commit_ready", 32'(bus.io_refill_ready), 32'd1);
        check("post_commit_busy", 32'(bus.io_busy), 32'd0);
        tick();

        // ---- partial refill: 3 beats, last on the 3rd ----
        line = '0;
        for (int k = 0; k < 3; k++) line[32*k +: 32] = 32'h200 + 32'(k);
        push_wr(7'h2A, 8'h07, line);
        for (int k = 0; k < 3; k++)
            send_beat(7'h2A, 32'h200 + 32'(k), k == 2);
        @(negedge clk);
        check("partial_commit_mask", 32'(bus.sram_w_maskOH), 32'h07);
        tick();

        // ---- store to refilled set accepted with the last beat ----
        line = '0;
        for (int k = 0; k < 8; k++) line[32*k +: 32] = 32'h300 + 32'(k);
        push_wr(7'h15, 8'hFF, line);
        push_wr(7'h15, 8'h20, lane(3'd5, 32'hDEAD));
        for (int k = 0; k < 7; k++)
            send_beat(7'h15, 32'h300 + 32'(k), 1'b0);
        bus.io_refill_valid = 1'b1;
        bus.io_refill_data  = 32'h307;
        bus.io_refill_last  = 1'b1;
        bus.io_st_valid     = 1'b1;
        bus.io_st_addr      = 7'h15;
        bus.io_st_bank      = 3'd5;
        bus.io_st_data      = 32'hDEAD;
        bus.io_rd_valid     = 1'b1;
        bus.io_rd_addr      = 7'h15;
        @(negedge clk);
        check("same_cycle_refill_ready", 32'(bus.io_refill_ready), 32'd1);
        check("same_cycle_st_ready", 32'(bus.io_st_ready), 32'd1);
        tick();
        bus.io_refill_valid = 1'b0;
        bus.io_refill_last  = 1'b0;
        bus.io_st_valid     = 1'b0;
        @(negedge clk);
        check("raw_t1_mask", 32'(bus.sram_w_maskOH), 32'hFF);
        check("raw_t1_hazard", 32'(bus.io_rd_hazard), 32'd1);
        tick();
        @(negedge clk);
        check("raw_t2_mask", 32'(bus.sram_w_maskOH), 32'h20);
        check("raw_t2_hazard", 32'(bus.io_rd_hazard), 32'd1);
        tick();
        @(negedge clk);
        check("raw_t3_hazard", 32'(bus.io_rd_hazard), 32'd0);
        check("raw_t3_w_en", 32'(bus.sram_w_en), 32'd0);
        tick();
        bus.io_rd_valid = 1'b0;

        // ---- three back-to-back stores around a COMMIT ----
        push_wr(7'h50, 8'h01, lane(3'd0, 32'h77));
        push_wr(7'h51, 8'h02, lane(3'd1, 32'hA));
        push_wr(7'h52, 8'h04, lane(3'd2, 32'hB));
        push_wr(7'h53, 8'h08, lane(3'd3, 32'hC));
        bus.io_refill_valid = 1'b1;
        bus.io_refill_addr  = 7'h50;
        bus.io_refill_data  = 32'h77;
        bus.io_refill_last  = 1'b1;
        bus.io_st_valid     = 1'b1;
        bus.io_st_addr      = 7'h51;
        bus.io_st_bank      = 3'd1;
        bus.io_st_data      = 32'hA;
        @(negedge clk);
        check("b2b_c0_st_ready", 32'(bus.io_st_ready), 32'd1);
        tick();
        bus.io_refill_valid = 1'b0;
        bus.io_refill_last  = 1'b0;
        bus.io_st_addr      = 7'h52;
        bus.io_st_bank      = 3'd2;
        bus.io_st_data      = 32'hB;
        @(negedge clk);
        check("b2b_c1_st_ready", 32'(bus.io_st_ready), 32'd1);
        check("b2b_c1_mask", 32'(bus.sram_w_maskOH), 32'h01);
        tick();
        bus.io_st_addr = 7'h53;
        bus.io_st_bank = 3'd3;
        bus.io_st_data = 32'hC;
        @(negedge clk);
        check("b2b_c2_st_ready_full", 32'(bus.io_st_ready), 32'd0);
        check("b2b_c2_mask", 32'(bus.sram_w_maskOH), 32'h02);
        tick();
        @(negedge clk);
        check("b2b_c3_st_ready", 32'(bus.io_st_ready), 32'd1);
        check("b2b_c3_mask", 32'(bus.sram_w_maskOH), 32'h04);
        tick();
        bus.io_st_valid = 1'b0;
        @(negedge clk);
        check("b2b_c4_mask", 32'(bus.sram_w_maskOH), 32'h08);
        tick();
        @(negedge clk);
        check("b2b_c5_w_en", 32'(bus.sram_w_en), 32'd0);
        check("b2b_c5_busy", 32'(bus.io_busy), 32'd0);
        tick();

        // ---- reset mid-FILL with a store pending ----
        for (int k = 0; k < 3; k++)
            send_beat(7'h33, 32'h400 + 32'(k), 1'b0);
        bus.io_refill_valid = 1'b1;
        bus.io_refill_data  = 32'h403;
        bus.io_st_valid     = 1'b1;
        bus.io_st_addr      = 7'h34;
        bus.io_st_bank      = 3'd2;
        bus.io_st_data      = 32'hBEEF;
        bus.io_rd_valid     = 1'b1;
        bus.io_rd_addr      = 7'h34;
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_w_en", 32'(bus.sram_w_en), 32'd0);
        check("midrst_busy", 32'(bus.io_busy), 32'd0);
        check("midrst_hazard", 32'(bus.io_rd_hazard), 32'd0);
        do_reset(1'b0);
        bus.io_rd_valid = 1'b1;
        bus.io_rd_addr  = 7'h34;
        @(negedge clk);
        check("postrst_sq_hazard", 32'(bus.io_rd_hazard), 32'd0);
        check("postrst_busy", 32'(bus.io_busy), 32'd0);
        bus.io_rd_addr = 7'h33;
        #1;
        check("postrst_fill_hazard", 32'(bus.io_rd_hazard), 32'd0);
        tick();
        bus.io_rd_valid = 1'b0;
        push_wr(7'h01, 8'h01, lane(3'd0, 32'h55));
        send_beat(7'h01, 32'h55, 1'b1);
        @(negedge clk);
        check("postrst_first_beat_mask", 32'(bus.sram_w_maskOH), 32'h01);
        tick();

        repeat (3) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
